// File: rtl/fe_fifo_packer.sv
// fe_fifo_packer: packs capture-stage FIFO entries into 16-bit words.
// Data entries become one word with a saturated 3-bit timestamp. TIME entries
// become two words carrying the full 16-bit timestamp. A small circular queue
// absorbs bursts while a two-word record drains or downstream is full.

`ifndef FE_FIFO_CMD_TIME
`define FE_FIFO_CMD_TIME 2'd2
`endif

module fe_fifo_packer #(
  parameter int          pQUEUE_DEPTH = 4,
  parameter logic [1:0]  pCMD_TIME    = `FE_FIFO_CMD_TIME,
  parameter int          pCOUNT_WIDTH = 16
) (
  input  logic                    fe_clk,
  input  logic                    reset_i,
  input  logic                    I_fifo_wr,
  input  logic [1:0]              I_fifo_command,
  input  logic [15:0]             I_fifo_time,
  input  logic [7:0]              I_fifo_data,
  input  logic                    I_flush,
  input  logic                    I_out_full,
  output logic                    O_out_wr,
  output logic [15:0]             O_out_data,
  output logic                    O_busy,
  output logic                    O_overflow,
  output logic                    O_ts_clipped,
  output logic [pCOUNT_WIDTH-1:0] O_word_count
);

  localparam int ptr_width = $clog2(pQUEUE_DEPTH);
  localparam int cnt_width = ptr_width + 1;
  localparam logic [cnt_width-1:0] full_count = cnt_width'(pQUEUE_DEPTH);

  typedef struct packed {
    logic [1:0]  cmd;
    logic [15:0] tstamp;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    TAIL = 1'b1
  } state_t;

  entry_t                 mem [pQUEUE_DEPTH];
  logic [ptr_width-1:0]   wr_ptr;
  logic [ptr_width-1:0]   rd_ptr;
  logic [cnt_width-1:0]   count;
  logic [7:0]             tail_q;
  state_t                 state_q;
  state_t                 state_d;

  entry_t                 head;
  logic                   is_time;
  logic                   queue_full;
  logic                   push;
  logic                   pop;
  logic                   emit;
  logic                   set_clip;
  logic [15:0]            word;
  logic [2:0]             ts3;

  assign head       = mem[rd_ptr];
  assign is_time    = (head.cmd == pCMD_TIME);
  assign queue_full = (count == full_count);
  // Flush discards a coincident entry; a full queue drops it even if a pop happens.
  assign push       = I_fifo_wr && !queue_full && !I_flush && !reset_i;
  assign ts3        = (|head.tstamp[15:3]) ? 3'd7 : head.tstamp[2:0];
  assign O_busy     = (count != '0) || (state_q != IDLE);

  // Next-state and word selection: IDLE pops and emits, TAIL emits the second TIME word.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    pop      = 1'b0;
    emit     = 1'b0;
    set_clip = 1'b0;
    word     = '0;
    case (state_q)
      IDLE: begin
        if (count != '0 && !I_out_full) begin
          pop  = 1'b1;
          emit = 1'b1;
          if (is_time) begin
            word    = {head.cmd, 1'b0, 3'b000, 2'b00, head.tstamp[15:8]};
            state_d = TAIL;
          end else begin
            word     = {head.cmd, 1'b0, ts3, 2'b00, head.data};
            set_clip = |head.tstamp[15:3];
          end
        end
      end
      TAIL: begin
        if (!I_out_full) begin
          emit    = 1'b1;
          word    = {pCMD_TIME, 1'b1, 3'b000, 2'b00, tail_q};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Queue storage write; contents are only meaningful below the occupancy count.
  always_ff @(posedge fe_clk) begin
    // NOTE: the storage array has no reset; pointers and count define validity.
    if (push) mem[wr_ptr] <= '{cmd: I_fifo_command, tstamp: I_fifo_time, data: I_fifo_data};
  end

  // Control state, queue pointers, output register, sticky flags and word counter.
  always_ff @(posedge fe_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset_i) begin
      state_q      <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      tail_q       <= '0;
      O_out_wr     <= 1'b0;
      O_out_data   <= '0;
      O_overflow   <= 1'b0;
      O_ts_clipped <= 1'b0;
      O_word_count <= '0;
    end else if (I_flush) begin
      state_q      <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      tail_q       <= '0;
      O_out_wr     <= 1'b0;
      O_overflow   <= 1'b0;
      O_ts_clipped <= 1'b0;
      O_word_count <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + ptr_width'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_width'(1);
      case ({push, pop})
        2'b10:   count <= count + cnt_width'(1);
        2'b01:   count <= count - cnt_width'(1);
        default: count <= count;
      endcase
      if (pop && is_time) tail_q <= head.tstamp[7:0];
      O_out_wr <= emit;
      if (emit) O_out_data <= word;
      if (I_fifo_wr && queue_full) O_overflow <= 1'b1;
      if (set_clip) O_ts_clipped <= 1'b1;
      if (emit && O_word_count != '1) O_word_count <= O_word_count + pCOUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fe_fifo_packer.sv
// Self-checking bench for fe_fifo_packer: a scoreboard queue of expected words
// is filled as entries are driven and drained by a monitor on the falling edge.

module tb_fe_fifo_packer;

  localparam logic [1:0] cmd_time = 2'd2;

  logic        fe_clk = 1'b0;
  logic        reset_i;
  logic        I_fifo_wr;
  logic [1:0]  I_fifo_command;
  logic [15:0] I_fifo_time;
  logic [7:0]  I_fifo_data;
  logic        I_flush;
  logic        I_out_full;
  logic        O_out_wr;
  logic [15:0] O_out_data;
  logic        O_busy;
  logic        O_overflow;
  logic        O_ts_clipped;
  logic [15:0] O_word_count;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [15:0] exp_q [$];
  int          out_cycles [$];

  fe_fifo_packer #(
    .pQUEUE_DEPTH(4),
    .pCMD_TIME   (cmd_time),
    .pCOUNT_WIDTH(16)
  ) dut (
    .fe_clk        (fe_clk),
    .reset_i       (reset_i),
    .I_fifo_wr     (I_fifo_wr),
    .I_fifo_command(I_fifo_command),
    .I_fifo_time   (I_fifo_time),
    .I_fifo_data   (I_fifo_data),
    .I_flush       (I_flush),
    .I_out_full    (I_out_full),
    .O_out_wr      (O_out_wr),
    .O_out_data    (O_out_data),
    .O_busy        (O_busy),
    .O_overflow    (O_overflow),
    .O_ts_clipped  (O_ts_clipped),
    .O_word_count  (O_word_count)
  );

  always #5 fe_clk = ~fe_clk;

  always @(posedge fe_clk) cycle <= cycle + 1;

  // Scoreboard monitor: every emitted word must match the oldest expected word.
  always @(negedge fe_clk) begin
    if (!reset_i && O_out_wr) begin
      checks++;
      out_cycles.push_back(cycle);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %h, scoreboard empty", O_out_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (O_out_data !== e) begin
          errors++;
          $display("FAIL word_data: got %h, expected %h", O_out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  // Reference packing of one entry into its expected word(s).
  task automatic expect_entry(input logic [1:0] c, input logic [15:0] t, input logic [7:0] d);
    logic [2:0] ts3;
    if (c == cmd_time) begin
      exp_q.push_back({c, 1'b0, 5'b00000, t[15:8]});
      exp_q.push_back({c, 1'b1, 5'b00000, t[7:0]});
    end else begin
      ts3 = (t > 16'd7) ? 3'd7 : t[2:0];
      exp_q.push_back({c, 1'b0, ts3, 2'b00, d});
    end
  endtask

  task automatic set_entry(input logic [1:0] c, input logic [15:0] t, input logic [7:0] d);
    I_fifo_wr      = 1'b1;
    I_fifo_command = c;
    I_fifo_time    = t;
    I_fifo_data    = d;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || O_busy) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || O_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d busy=%b, expected 0 and 0", name, exp_q.size(), O_busy);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; I_fifo_wr = 1'b0; I_fifo_command = '0; I_fifo_time = '0;
    I_fifo_data = '0; I_flush = 1'b0; I_out_full = 1'b0;
    tick(); tick();
    checks++;
    if ({O_out_wr, O_out_data, O_busy, O_overflow, O_ts_clipped, O_word_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: wr=%b data=%h busy=%b ovf=%b clip=%b cnt=%0d, expected all 0",
               O_out_wr, O_out_data, O_busy, O_overflow, O_ts_clipped, O_word_count);
    end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    set_entry(2'd1, 16'd3, 8'hA5);
    expect_entry(2'd1, 16'd3, 8'hA5);
    tick();                       // edge N
    I_fifo_wr = 1'b0;
    checks++;
    if (O_out_wr !== 1'b0) begin
      errors++; $display("FAIL single_early: out_wr=%b, expected 0", O_out_wr);
    end
    tick();                       // edge N+1
    checks++;
    if (O_out_wr !== 1'b1 || O_out_data !== 16'h4CA5 || O_word_count !== 16'd1) begin
      errors++;
      $display("FAIL single_word: wr=%b data=%h cnt=%0d, expected 1 4ca5 1", O_out_wr, O_out_data, O_word_count);
    end
    tick();
    checks++;
    if (O_out_wr !== 1'b0 || O_out_data !== 16'h4CA5) begin
      errors++;
      $display("FAIL single_hold: wr=%b data=%h, expected 0 4ca5", O_out_wr, O_out_data);
    end
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    out_cycles.delete();
    set_entry(cmd_time, 16'h1234, 8'h00);
    expect_entry(cmd_time, 16'h1234, 8'h00);
    tick();
    set_entry(2'd1, 16'd0, 8'h5A);
    expect_entry(2'd1, 16'd0, 8'h5A);
    tick();
    I_fifo_wr = 1'b0;
    wait_drain("b2b");
    tick();
    checks++;
    if (out_cycles.size() != 3 || out_cycles[1] != out_cycles[0] + 1 || out_cycles[2] != out_cycles[1] + 1) begin
      errors++;
      $display("FAIL b2b_gapless: %0d words not on consecutive cycles, expected 3 consecutive", out_cycles.size());
    end
    checks++;
    if (O_overflow !== 1'b0 || O_word_count !== 16'd4) begin
      errors++;
      $display("FAIL b2b_flags: ovf=%b cnt=%0d, expected 0 4", O_overflow, O_word_count);
    end
  endtask

  task automatic test_overflow();
    I_out_full = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      set_entry(2'd1, 16'd1, 8'(i));
      if (i <= 4) expect_entry(2'd1, 16'd1, 8'(i));
      tick();
      checks++;
      if (O_out_wr !== 1'b0) begin
        errors++; $display("FAIL full_stall: out_wr=%b while full, expected 0", O_out_wr);
      end
    end
    I_fifo_wr = 1'b0;
    tick();
    checks++;
    if (O_overflow !== 1'b1 || O_busy !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flags: ovf=%b busy=%b, expected 1 1", O_overflow, O_busy);
    end
    I_out_full = 1'b0;
    wait_drain("overflow");
    checks++;
    if (O_word_count !== 16'd8 || O_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_count: cnt=%0d ovf=%b, expected 8 1", O_word_count, O_overflow);
    end
  endtask

  task automatic test_clip();
    set_entry(2'd1, 16'd9, 8'h33);
    expect_entry(2'd1, 16'd9, 8'h33);
    tick();
    I_fifo_wr = 1'b0;
    tick();
    checks++;
    if (O_out_data !== 16'h5C33 || O_ts_clipped !== 1'b1) begin
      errors++;
      $display("FAIL clip_word: data=%h clip=%b, expected 5c33 1", O_out_data, O_ts_clipped);
    end
    set_entry(2'd0, 16'd2, 8'h44);
    expect_entry(2'd0, 16'd2, 8'h44);
    tick();
    I_fifo_wr = 1'b0;
    tick();
    checks++;
    if (O_out_data !== 16'h0844 || O_ts_clipped !== 1'b1) begin
      errors++;
      $display("FAIL clip_sticky: data=%h clip=%b, expected 0844 1", O_out_data, O_ts_clipped);
    end
    wait_drain("clip");
  endtask

  task automatic test_flush();
    set_entry(cmd_time, 16'hBEEF, 8'h00);
    exp_q.push_back({cmd_time, 1'b0, 5'b00000, 8'hBE});  // word1 must never appear
    tick();
    I_fifo_wr = 1'b0;
    tick();                       // word0 emitted, now in TAIL
    checks++;
    if (O_out_wr !== 1'b1 || O_out_data !== 16'h80BE || O_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_word0: wr=%b data=%h busy=%b, expected 1 80be 1", O_out_wr, O_out_data, O_busy);
    end
    I_flush = 1'b1;
    set_entry(2'd1, 16'd1, 8'h77);  // discarded by the flush
    tick();
    I_flush = 1'b0;
    I_fifo_wr = 1'b0;
    checks++;
    if (O_out_wr !== 1'b0 || O_busy !== 1'b0 || O_word_count !== 16'd0 ||
        O_overflow !== 1'b0 || O_ts_clipped !== 1'b0 || O_out_data !== 16'h80BE) begin
      errors++;
      $display("FAIL flush_state: wr=%b busy=%b cnt=%0d ovf=%b clip=%b data=%h, expected 0 0 0 0 0 80be",
               O_out_wr, O_busy, O_word_count, O_overflow, O_ts_clipped, O_out_data);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (O_word_count !== 16'd0 || O_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_quiet: cnt=%0d busy=%b, expected 0 0", O_word_count, O_busy);
    end
    wait_drain("flush");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_clip();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
